// File: rtl/cache_pkg.sv
// Shared types and SRAM line field positions for the 2-way cache controller.
package cache_pkg;
    typedef enum logic [1:0] {
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    localparam int VALID_BIT = 155;
    localparam int DIRTY_BIT = 154;
    localparam int TAG_MSB   = 153;
    localparam int TAG_LSB   = 128;
    localparam int LINE_MSB  = 127;
    localparam int IDX_W     = 2;
    localparam int OFF_W     = 2;
endpackage

// File: rtl/cache_word_merge.sv
// Replaces one 32-bit word of a cache line, selected by the word offset.
module cache_word_merge
    import cache_pkg::*;
#(
    parameter int LINE_W = 128
) (
    input  logic [LINE_W-1:0] line,
    input  logic [OFF_W-1:0]  offset,
    input  logic [31:0]       word,
    output logic [LINE_W-1:0] merged
);
    always_comb begin
        merged = line;
        merged[int'(offset)*32 +: 32] = word;
    end
endmodule

// File: rtl/cache_ctrl_2way.sv
// Write-back, write-allocate controller for a 2-way 4-set cache SRAM with
// dirty-victim write-back, line refill and saturating hit/miss counters.
module cache_ctrl_2way
    import cache_pkg::*;
#(
    parameter int TAG_W  = 26,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          proc_read,
    input  logic                          proc_write,
    input  logic [TAG_W+IDX_W+OFF_W-1:0]  proc_addr,
    input  logic [31:0]                   proc_wdata,
    output logic [31:0]                   proc_rdata,
    output logic                          proc_stall,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [TAG_W+IDX_W-1:0]        mem_addr,
    output logic [LINE_W-1:0]             mem_wdata,
    input  logic [LINE_W-1:0]             mem_rdata,
    input  logic                          mem_ready,
    output logic [TAG_W+IDX_W+OFF_W-1:0]  sram_addr,
    output logic [LINE_W+TAG_W+1:0]       sram_wdata,
    output logic                          sram_write,
    input  logic [LINE_W+TAG_W+1:0]       sram_rdata,
    input  logic                          sram_hit,
    output logic [CNT_W-1:0]              hit_cnt,
    output logic [CNT_W-1:0]              miss_cnt
);
    localparam int A_W = TAG_W + IDX_W + OFF_W;

    state_t            state, state_nx;
    logic              prev_compare;
    logic              req, victim_dirty, hit_inc, miss_inc;
    logic [LINE_W-1:0] merged_line;

    assign req          = proc_read | proc_write;
    assign victim_dirty = sram_rdata[VALID_BIT] & sram_rdata[DIRTY_BIT];
    assign sram_addr    = proc_addr;
    assign proc_rdata   = sram_rdata[int'(proc_addr[OFF_W-1:0])*32 +: 32];

    cache_word_merge #(.LINE_W(LINE_W)) u_merge (
        .line   (sram_rdata[LINE_MSB:0]),
        .offset (proc_addr[OFF_W-1:0]),
        .word   (proc_wdata),
        .merged (merged_line)
    );

    always_comb begin
        state_nx   = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = proc_addr[A_W-1:OFF_W];
        mem_wdata  = sram_rdata[LINE_MSB:0];
        sram_write = 1'b0;
        sram_wdata = {1'b1, 1'b1, sram_rdata[TAG_MSB:TAG_LSB], merged_line};
        proc_stall = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        case (state)
            S_COMPARE: begin
                if (req) begin
                    if (sram_hit) begin
                        sram_write = proc_write;
                        hit_inc    = prev_compare;
                    end else begin
                        proc_stall = 1'b1;
                        miss_inc   = 1'b1;
                        state_nx   = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                // SRAM output still shows the victim: address is held and nothing is written
                proc_stall = req;
                mem_write  = 1'b1;
                mem_addr   = {sram_rdata[TAG_MSB:TAG_LSB], proc_addr[IDX_W+OFF_W-1:OFF_W]};
                if (mem_ready) state_nx = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                proc_stall = req;
                mem_read   = 1'b1;
                if (mem_ready) begin
                    sram_write = 1'b1;
                    sram_wdata = {1'b1, 1'b0, proc_addr[A_W-1:IDX_W+OFF_W], mem_rdata};
                    state_nx   = S_COMPARE;
                end
            end
            default: state_nx = S_COMPARE;
        endcase
        if (rst) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            sram_write = 1'b0;
            proc_stall = 1'b0;
            hit_inc    = 1'b0;
            miss_inc   = 1'b0;
            state_nx   = S_COMPARE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_COMPARE;
            prev_compare <= 1'b1;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
        end else begin
            state        <= state_nx;
            prev_compare <= (state == S_COMPARE);
            if (hit_inc && hit_cnt != '1)   hit_cnt  <= hit_cnt + 1'b1;
            if (miss_inc && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        end
    end
endmodule
